// File: rtl/mcp3202_spi_responder.sv
// MCP3202 ADC emulator: SPI slave decoding START/SGL/ODD/MSBF and returning null + 12 data bits.
// Define MCP3202_RESP_LSBF_EN to append the LSB-first tail (B1..B11) when MSBF=0.
module mcp3202_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [11:0] ch0_data,
    input  logic [11:0] ch1_data,
    output logic        conv_pulse,
    output logic [1:0]  conv_cfg,
    output logic [11:0] conv_data,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, WAIT_START, CFG, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_prev, cs_prev;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [4:0]             bit_cnt, edge_n;
    logic                   sgl, odd;
    logic [11:0]            shreg;
    logic [11:0]            sel_data;
    logic [12:0]            diff;
`ifdef MCP3202_RESP_LSBF_EN
    logic                   msbf;
    logic [10:0]            lsb_sr;
`endif

    // cs chain resets low so a cs held low across reset is not seen as a new frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    always_comb begin
        sck_s    = sck_sync[SYNC_STAGES-1];
        cs_s     = cs_sync[SYNC_STAGES-1];
        mosi_s   = mosi_sync[SYNC_STAGES-1];
        sck_rise = sck_s & ~sck_prev;
        sck_fall = ~sck_s & sck_prev;
        cs_rise  = cs_s & ~cs_prev;
        cs_fall  = ~cs_s & cs_prev;
        edge_n   = bit_cnt + 5'd1;
    end

    // Differential modes are unipolar: a negative 13-bit difference reads as zero
    always_comb begin
        diff = odd ? ({1'b0, ch1_data} - {1'b0, ch0_data})
                   : ({1'b0, ch0_data} - {1'b0, ch1_data});
        if (sgl)
            sel_data = odd ? ch1_data : ch0_data;
        else if (diff[12])
            sel_data = '0;
        else
            sel_data = diff[11:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sgl        <= 1'b0;
            odd        <= 1'b0;
            shreg      <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            conv_pulse <= 1'b0;
            conv_cfg   <= 2'b00;
            conv_data  <= '0;
            frame_err  <= 1'b0;
`ifdef MCP3202_RESP_LSBF_EN
            msbf       <= 1'b0;
            lsb_sr     <= '0;
`endif
        end else begin
            conv_pulse <= 1'b0;
            frame_err  <= 1'b0;
            if (cs_rise) begin
                if (state == CFG || (state == SHIFT && bit_cnt < 5'd13))
                    frame_err <= 1'b1;
                state   <= IDLE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state   <= WAIT_START;
                        miso    <= 1'b0;
                        miso_oe <= 1'b1;
                    end
                    WAIT_START: if (sck_rise && mosi_s) begin
                        state   <= CFG;
                        bit_cnt <= '0;
                    end
                    CFG: if (sck_rise) begin
                        case (bit_cnt)
                            5'd0: begin sgl <= mosi_s; bit_cnt <= edge_n; end
                            5'd1: begin odd <= mosi_s; bit_cnt <= edge_n; end
                            default: begin
`ifdef MCP3202_RESP_LSBF_EN
                                msbf   <= mosi_s;
                                lsb_sr <= sel_data[11:1];
`endif
                                shreg      <= sel_data;
                                conv_data  <= sel_data;
                                conv_cfg   <= {sgl, odd};
                                conv_pulse <= 1'b1;
                                bit_cnt    <= '0;
                                state      <= SHIFT;
                            end
                        endcase
                    end
                    SHIFT: if (sck_fall) begin
                        bit_cnt <= edge_n;
                        if (edge_n == 5'd1) begin
                            miso <= 1'b0;
                        end else if (edge_n <= 5'd13) begin
                            miso  <= shreg[11];
                            shreg <= {shreg[10:0], 1'b0};
`ifdef MCP3202_RESP_LSBF_EN
                        end else if (!msbf && edge_n <= 5'd24) begin
                            miso   <= lsb_sr[0];
                            lsb_sr <= {1'b0, lsb_sr[10:1]};
`endif
                        end else begin
                            miso  <= 1'b0;
                            state <= DONE;
                        end
                    end
                    DONE: miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Self-checking bench for mcp3202_spi_responder: SPI master stimulus against a frame-level reference model.
module tb_mcp3202_spi_responder;

    localparam int HALF = 8;
`ifdef MCP3202_RESP_LSBF_EN
    localparam bit LSBF = 1'b1;
`else
    localparam bit LSBF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, conv_pulse, frame_err;
    logic [11:0] ch0_data = '0;
    logic [11:0] ch1_data = '0;
    logic [1:0]  conv_cfg;
    logic [11:0] conv_data;

    int tests_run = 0;
    int tests_failed = 0;
    int pulse_cnt = 0;
    int err_cnt = 0;
    int err_oe_bad = 0;

    mcp3202_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .ch0_data(ch0_data), .ch1_data(ch1_data),
        .conv_pulse(conv_pulse), .conv_cfg(conv_cfg), .conv_data(conv_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conv_pulse) pulse_cnt++;
        if (frame_err) err_cnt++;
        if (frame_err && miso_oe) err_oe_bad++;
    end

    function automatic int model_value(input bit sgl, input bit odd, input int c0, input int c1);
        int d;
        if (sgl) return odd ? c1 : c0;
        d = odd ? (c1 - c0) : (c0 - c1);
        return (d < 0) ? 0 : d;
    endfunction

    // k = index of the falling edge after MSBF capture, starting at 0 for the null bit
    function automatic logic [31:0] model_stream(input int v, input bit msbf, input int nfall);
        logic [31:0] s;
        s = '0;
        for (int k = 1; k < nfall; k++) begin
            if (k <= 12) s[k] = ((v >> (12 - k)) & 1) != 0;
            else if (LSBF && !msbf && k <= 23) s[k] = ((v >> (k - 12)) & 1) != 0;
        end
        return s;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        sck = 1'b0; mosi = b; wait_clk(HALF);
        sck = 1'b1; wait_clk(HALF);
    endtask

    task automatic run_frame(input int lead, input bit sgl, input bit odd, input bit msbf,
                             input int nfall, input bit scramble, output logic [31:0] rx);
        rx = '0;
        cs = 1'b0; wait_clk(HALF);
        for (int i = 0; i < lead; i++) send_bit(1'b0);
        send_bit(1'b1); send_bit(sgl); send_bit(odd); send_bit(msbf);
        if (scramble) begin
            ch0_data = 12'($urandom);
            ch1_data = 12'($urandom);
        end
        for (int k = 0; k < nfall; k++) begin
            sck = 1'b0; wait_clk(HALF);
            rx[k] = miso;
            sck = 1'b1; wait_clk(HALF);
        end
        cs = 1'b1; wait_clk(HALF);
        sck = 1'b0; mosi = 1'b0; wait_clk(HALF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs = 1'b1;
        ch0_data = 12'h5A5; ch1_data = 12'h3C3;
        wait_clk(5);
        tests_run++;
        if ({miso, miso_oe, conv_pulse, conv_cfg, conv_data, frame_err} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got miso=%b oe=%b pulse=%b cfg=%b data=%h err=%b, expected all zero",
                     miso, miso_oe, conv_pulse, conv_cfg, conv_data, frame_err);
        end
        rst_n = 1'b1; wait_clk(HALF);
        tests_run++;
        if (miso_oe !== 1'b0 || err_cnt !== 0 || pulse_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_idle: got oe=%b err_cnt=%0d pulse_cnt=%0d, expected 0/0/0",
                     miso_oe, err_cnt, pulse_cnt);
        end
    endtask

    typedef struct {
        int lead; bit sgl; bit odd; bit msbf; int c0; int c1;
    } case_t;

    task automatic test_directed();
        case_t cases[5];
        logic [31:0] rx, exp;
        int v, p0, e0;
        cases[0] = '{0, 1'b1, 1'b0, 1'b1, 'hA5C, 'h000};
        cases[1] = '{0, 1'b0, 1'b1, 1'b1, 'h100, 'h300};
        cases[2] = '{0, 1'b0, 1'b0, 1'b1, 'h100, 'h300};
        cases[3] = '{3, 1'b1, 1'b1, 1'b1, 'h000, 'hFFF};
        cases[4] = '{0, 1'b1, 1'b0, 1'b0, 'h801, 'h000};
        for (int i = 0; i < 5; i++) begin
            ch0_data = 12'(cases[i].c0); ch1_data = 12'(cases[i].c1);
            p0 = pulse_cnt; e0 = err_cnt;
            v = model_value(cases[i].sgl, cases[i].odd, cases[i].c0, cases[i].c1);
            exp = model_stream(v, cases[i].msbf, 26);
            run_frame(cases[i].lead, cases[i].sgl, cases[i].odd, cases[i].msbf, 26, 1'b0, rx);
            tests_run++;
            if (rx !== exp) begin
                tests_failed++;
                $display("FAIL directed%0d_miso: got %h expected %h", i, rx, exp);
            end
            tests_run++;
            if (conv_data !== 12'(v) || conv_cfg !== {cases[i].sgl, cases[i].odd}) begin
                tests_failed++;
                $display("FAIL directed%0d_conv: got data=%h cfg=%b expected data=%h cfg=%b",
                         i, conv_data, conv_cfg, 12'(v), {cases[i].sgl, cases[i].odd});
            end
            tests_run++;
            if (pulse_cnt - p0 !== 1 || err_cnt - e0 !== 0 || miso_oe !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed%0d_flags: got pulses=%0d errs=%0d oe=%b expected 1/0/0",
                         i, pulse_cnt - p0, err_cnt - e0, miso_oe);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rx, exp;
        int v, p0, c0, c1, lead;
        bit sgl, odd, msbf;
        for (int i = 0; i < 14; i++) begin
            c0 = int'($urandom_range(0, 4095)); c1 = int'($urandom_range(0, 4095));
            sgl = 1'($urandom); odd = 1'($urandom); msbf = 1'($urandom);
            lead = int'($urandom_range(0, 3));
            ch0_data = 12'(c0); ch1_data = 12'(c1);
            p0 = pulse_cnt;
            v = model_value(sgl, odd, c0, c1);
            exp = model_stream(v, msbf, 26);
            run_frame(lead, sgl, odd, msbf, 26, 1'b1, rx);
            tests_run++;
            if (rx !== exp || conv_data !== 12'(v) || conv_cfg !== {sgl, odd} || pulse_cnt - p0 !== 1) begin
                tests_failed++;
                $display("FAIL random%0d: got rx=%h data=%h cfg=%b pulses=%0d expected rx=%h data=%h cfg=%b pulses=1",
                         i, rx, conv_data, conv_cfg, pulse_cnt - p0, exp, 12'(v), {sgl, odd});
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rx, exp;
        int e0, b0;
        ch0_data = 12'h6D3; ch1_data = 12'h111;
        e0 = err_cnt; b0 = err_oe_bad;
        run_frame(0, 1'b1, 1'b0, 1'b1, 6, 1'b0, rx);
        tests_run++;
        if (err_cnt - e0 !== 1 || err_oe_bad !== b0 || miso_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_err: got err_pulses=%0d oe_overlap=%0d oe=%b expected 1/0/0",
                     err_cnt - e0, err_oe_bad - b0, miso_oe);
        end
        ch0_data = 12'h2B7;
        e0 = err_cnt;
        exp = model_stream(12'h2B7, 1'b1, 26);
        run_frame(1, 1'b1, 1'b0, 1'b1, 26, 1'b0, rx);
        tests_run++;
        if (rx !== exp || conv_data !== 12'h2B7 || err_cnt !== e0) begin
            tests_failed++;
            $display("FAIL abort_recover: got rx=%h data=%h errs=%0d expected rx=%h data=2b7 errs=0",
                     rx, conv_data, err_cnt - e0, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rx, exp;
        int p0;
        ch0_data = 12'hFFF;
        cs = 1'b0; wait_clk(HALF);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int k = 0; k < 5; k++) begin
            sck = 1'b0; wait_clk(HALF);
            sck = 1'b1; wait_clk(HALF);
        end
        rst_n = 1'b0;
        wait_clk(1);
        tests_run++;
        if ({miso, miso_oe, conv_pulse, conv_cfg, conv_data, frame_err} !== 18'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got miso=%b oe=%b pulse=%b cfg=%b data=%h err=%b, expected all zero",
                     miso, miso_oe, conv_pulse, conv_cfg, conv_data, frame_err);
        end
        wait_clk(2);
        rst_n = 1'b1; wait_clk(2);
        p0 = pulse_cnt;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        sck = 1'b0; wait_clk(HALF);
        tests_run++;
        if (pulse_cnt !== p0 || miso_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_no_cs_fall: got pulses=%0d oe=%b expected 0/0", pulse_cnt - p0, miso_oe);
        end
        cs = 1'b1; wait_clk(HALF);
        ch0_data = 12'hC3A;
        exp = model_stream(12'hC3A, 1'b1, 26);
        run_frame(0, 1'b1, 1'b0, 1'b1, 26, 1'b0, rx);
        tests_run++;
        if (rx !== exp || conv_data !== 12'hC3A) begin
            tests_failed++;
            $display("FAIL midreset_recover: got rx=%h data=%h expected rx=%h data=c3a", rx, conv_data, exp);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
